gt_uint_serial: RTL
===================

# gt_uint_serial

Bit-serial unsigned greater-than engine (Y = A > B) for area-constrained PIM mapping. It is the sequential counterpart of the combinational less-than benchmarks and evaluates the inverse relation. It latches two WIDTH-bit operands through a valid/ready handshake and ripples a single borrow register LSB-first, DIGIT bits per cycle. The result is presented on a held output handshake. It sits between an operand producer and a result consumer in the pimsynth benchmark set.

## Interface
- WIDTH, 32, operand width in bits.
- DIGIT, 1, bits processed per cycle. WIDTH % DIGIT must be 0, otherwise elaboration fails via a generate-time error.
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands A/B are valid.
- in_ready  output  1  block can accept operands. High only in IDLE.
- A  input  WIDTH  unsigned operand, sampled on accept.
- B  input  WIDTH  unsigned operand, sampled on accept.
- out_valid  output  1  Y is valid. High only in DONE.
- out_ready  input  1  consumer takes Y.
- Y  output  1  1 when A > B (unsigned), else 0.

## Operation
- States:
  - IDLE: in_ready=1.
  - RUN: compute.
  - DONE: out_valid=1.
- IDLE → RUN on in_valid && in_ready. On that edge:
  - A and B are loaded into shift registers sa and sb.
  - The borrow register br is cleared to 0.
  - The digit counter cnt is cleared to 0.
- RUN, each cycle:
  - The DIGIT LSBs of sa/sb pass through a DIGIT-deep borrow chain computing sb − sa, with bit i feeding bit i+1 and br as chain input.
  - br takes the chain borrow-out.
  - sa and sb shift right by DIGIT, zero-filled.
  - cnt increments.
- RUN → DONE on the cycle where cnt == N−1, with N = WIDTH/DIGIT. Y is registered from that cycle's final borrow-out.
- Borrow semantics: the final borrow of B − A is 1 exactly when A > B. Equal operands give Y=0.
- DONE → IDLE on out_ready. Y and out_valid hold stable until the handshake completes.
- A and B are don't-care outside the accept edge. in_valid is ignored in RUN and DONE.
- There is no bypass, so a new operand pair is never accepted in the same cycle a result is consumed.
- cnt width is clog2(N), minimum 1 bit. It wraps only via reload on accept, never in RUN.

## Timing
- Reset values:
  - state=IDLE, in_ready=1.
  - out_valid=0, Y=0.
  - br=0, cnt=0, sa=sb=0.
- Latency: accept at edge k → out_valid=1 after edge k+N. Defaults give 32 cycles; DIGIT=4 gives 8.
- Throughput: one comparison per N+2 cycles minimum (accept, N compute, consume).
- in_ready and out_valid are decoded from registered state only, so there is no combinational path from inputs to outputs.
- Reset asserted mid-RUN or mid-DONE:
  - The operation is aborted immediately and asynchronously, and all registers return to reset values.
  - The result is lost, and no out_valid pulse is produced after deassertion.
- out_ready held low in DONE: the block stays in DONE indefinitely with Y unchanged.
- Simultaneous out_ready=1 and in_valid=1 in DONE: the result is consumed, and the operand is not taken until the next cycle in IDLE.

## Structure
- Shared package gt_uint_serial_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - a function computing the counter width from WIDTH/DIGIT.
- The state encoding is two bits.
- Sub-module gt_uint_serial_cell holds the 1-bit borrow cell:
  - inputs a, b, bin; output bout = (~b & a) | (~(b ^ a) & bin);
  - it is instantiated DIGIT times in a generate chain.
- Top level holds the FSM, counter, and shift registers only.

## Test plan
- A=5, B=3, defaults, out_ready=1 → out_valid rises exactly 32 cycles after accept, Y=1. in_ready returns high one cycle later.
- A=B=0xFFFFFFFF → Y=0. Also A=0, B=1 → Y=0.
- A=0x80000000, B=0x7FFFFFFF → Y=1 (MSB decides in the last digit). Swapped operands → Y=0.
- Backpressure: out_ready low for 5 cycles in DONE → Y and out_valid are stable, in_ready=0, and a changing in_valid/A/B is ignored. A single-cycle out_ready then returns the block to IDLE.
- rst_n pulsed low at cycle 10 of RUN → all outputs reach reset values immediately. After release no out_valid appears, and a fresh A=7, B=9 completes with Y=0.
- DIGIT=4: A=0x00010000, B=0x0000FFFF → out_valid after 8 cycles, Y=1. Also 1000 random pairs match A > B.

Source files
------------

// File: rtl/gt_uint_serial_pkg.sv
// rtl/gt_uint_serial_pkg.sv - shared state encoding and sizing helper for gt_uint_serial
package gt_uint_serial_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Digit counter width: clog2 of the digit count, never below one bit.
  function automatic int cnt_width(input int width, input int digit);
    int n;
    n = width / digit;
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/gt_uint_serial_cell.sv
// rtl/gt_uint_serial_cell.sv - one-bit borrow cell for b - a with borrow-in
module gt_uint_serial_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic bout
);

  assign bout = (~b & a) | (~(b ^ a) & bin);

endmodule

// File: rtl/gt_uint_serial.sv
// rtl/gt_uint_serial.sv - bit-serial unsigned A > B, DIGIT bits per cycle, LSB first
module gt_uint_serial
  import gt_uint_serial_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             Y
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = cnt_width(WIDTH, DIGIT);

  if (WIDTH % DIGIT != 0) begin : g_bad_digit
    $error("gt_uint_serial: WIDTH must be a multiple of DIGIT");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic             br_q, br_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             y_q, y_d;

  // Borrow ripples from bit 0 upward; chain[DIGIT] is this cycle's borrow-out.
  logic [DIGIT:0] chain;
  assign chain[0] = br_q;

  for (genvar i = 0; i < DIGIT; i++) begin : g_cell
    gt_uint_serial_cell u_cell (
      .a    (sa_q[i]),
      .b    (sb_q[i]),
      .bin  (chain[i]),
      .bout (chain[i+1])
    );
  end

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    y_d     = y_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          sa_d    = A;
          sb_d    = B;
          br_d    = 1'b0;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        br_d = chain[DIGIT];
        sa_d = sa_q >> DIGIT;
        sb_d = sb_q >> DIGIT;
        if (cnt_q == CW'(N - 1)) begin
          y_d     = chain[DIGIT];
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      y_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign Y         = y_q;

endmodule
